// File: rtl/ibex_fetch_fifo_circ.sv
// Fetch FIFO between the prefetch bus side and the ID-stage aligner: circular word buffer
// with a zero-latency bypass, compressed/unaligned realignment and error attribution.
module ibex_fetch_fifo_circ #(
   parameter int unsigned NUM_REQS = 2,
   parameter bit          ResetAll = 1'b0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clear_i,
   output logic [NUM_REQS-1:0]           busy_o,
   output logic [$clog2(NUM_REQS+2)-1:0] level_o,
   input  logic                          in_valid_i,
   input  logic [31:0]                   in_addr_i,
   input  logic [31:0]                   in_rdata_i,
   input  logic                          in_err_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [31:0]                   out_addr_o,
   output logic [31:0]                   out_rdata_o,
   output logic                          out_err_o,
   output logic                          out_err_plus2_o
);

   localparam int unsigned DEPTH = NUM_REQS + 1;
   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned LW    = $clog2(DEPTH + 1);

   logic [PW-1:0] r_rdPtr;
   logic [PW-1:0] r_wrPtr;
   logic [LW-1:0] r_level;
   logic [31:1]   r_addr;
   logic [31:0]   r_data [DEPTH];
   logic          r_err  [DEPTH];

   logic [PW-1:0] w_rdPtrInc;
   logic [PW-1:0] w_wrPtrInc;
   logic          w_lvl1;
   logic          w_lvl2;
   logic          w_full;
   logic [31:0]   w_headData;
   logic          w_headErr;
   logic [31:0]   w_nextData;
   logic          w_nextErr;
   logic          w_valid;
   logic          w_compLo;
   logic          w_compHi;
   logic          w_comp;
   logic          w_fire;
   logic          w_pop;
   logic          w_push;
   logic          w_popStore;
   logic          w_pushStore;
   logic          w_write;
   logic          w_pushDropped;
   logic          w_unusedAddr;

   assign w_unusedAddr = in_addr_i[0];

   assign w_rdPtrInc = (r_rdPtr == PW'(DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
   assign w_wrPtrInc = (r_wrPtr == PW'(DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;

   assign w_lvl1 = (r_level != '0);
   assign w_lvl2 = (r_level >= LW'(2));
   assign w_full = (r_level == LW'(DEPTH));

   // Head and next words fall back to the incoming bus word when not yet stored
   assign w_headData = w_lvl1 ? r_data[r_rdPtr] : in_rdata_i;
   assign w_headErr  = w_lvl1 ? r_err[r_rdPtr]  : in_err_i;
   assign w_nextData = w_lvl2 ? r_data[w_rdPtrInc] : in_rdata_i;
   assign w_nextErr  = w_lvl2 ? r_err[w_rdPtrInc]  : (w_lvl1 & in_err_i);

   assign w_valid  = w_lvl1 | in_valid_i;
   assign w_compLo = (w_headData[1:0] != 2'b11) & ~w_headErr;
   assign w_compHi = (w_headData[17:16] != 2'b11) & ~w_headErr;

   always_comb begin
      out_valid_o     = w_valid;
      out_rdata_o     = w_headData;
      out_err_o       = w_headErr;
      out_err_plus2_o = 1'b0;
      w_comp          = w_compLo;
      if (r_addr[1]) begin
         out_rdata_o     = {w_nextData[15:0], w_headData[31:16]};
         out_valid_o     = w_compHi ? w_valid : (w_lvl2 | (w_lvl1 & in_valid_i));
         out_err_o       = w_headErr | (w_nextErr & ~w_compHi);
         out_err_plus2_o = w_nextErr & ~w_headErr;
         w_comp          = w_compHi;
      end
   end

   assign out_addr_o = {r_addr, 1'b0};
   assign level_o    = r_level;

   for (genvar i = 0; i < NUM_REQS; i++) begin : g_busy
      assign busy_o[i] = (r_level >= LW'(i + 2));
   end

   // A bypassed word consumed in its arrival cycle never enters the buffer
   assign w_fire        = out_valid_o & out_ready_i;
   assign w_pop         = w_fire & (r_addr[1] | ~w_compLo);
   assign w_push        = in_valid_i & ~(~w_lvl1 & w_pop);
   assign w_popStore    = w_pop & w_lvl1;
   assign w_pushStore   = w_push & (~w_full | w_popStore);
   assign w_write       = ~clear_i & w_pushStore;
   assign w_pushDropped = ~clear_i & w_push & w_full & ~w_popStore;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_level <= '0;
         r_addr  <= '0;
      end else if (clear_i) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_level <= '0;
         r_addr  <= in_addr_i[31:1];
      end else begin
         if (w_pushStore) r_wrPtr <= w_wrPtrInc;
         if (w_popStore)  r_rdPtr <= w_rdPtrInc;
         unique case ({w_pushStore, w_popStore})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_fire) r_addr <= r_addr + (w_comp ? 31'd1 : 31'd2);
      end
   end

   if (ResetAll) begin : g_storeRst
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_data[i] <= '0;
               r_err[i]  <= 1'b0;
            end
         end else if (w_write) begin
            r_data[r_wrPtr] <= in_rdata_i;
            r_err[r_wrPtr]  <= in_err_i;
         end
      end
   end else begin : g_storeNoRst
      always_ff @(posedge clk_i) begin
         if (w_write) begin
            r_data[r_wrPtr] <= in_rdata_i;
            r_err[r_wrPtr]  <= in_err_i;
         end
      end
   end

   // Pushing into a full buffer is only legal when the head leaves in the same cycle
   assert property (@(posedge clk_i) disable iff (!rst_ni) !w_pushDropped);

endmodule

// File: doc/ibex_fetch_fifo_circ.md
# ibex_fetch_fifo_circ

Parametrised fetch FIFO for the 32-bit instruction interface, sitting between the prefetch buffer's bus side and the ID-stage instruction aligner. Word entries are stored in a circular buffer with read/write pointers instead of a shift register. The block adds a fill-level output and a legal simultaneous push/pop when full. It keeps the bypass path, compressed/unaligned instruction realignment and error attribution.

## Interface
- NUM_REQS, 2, max outstanding bus requests (>=1); DEPTH = NUM_REQS+1 word entries
- ResetAll, 0, 1: data/err storage also reset to 0; 0: storage not reset
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  flush contents; load address from in_addr_i
- busy_o  out  NUM_REQS  busy_o[i] = (level >= i+2)
- level_o  out  $clog2(DEPTH+1)  stored word count
- in_valid_i  in  1  incoming fetch word valid
- in_addr_i  in  32  restart address, used only with clear_i; bit 0 ignored
- in_rdata_i  in  32  fetch word
- in_err_i  in  1  bus error for the word
- out_valid_o  out  1  instruction valid
- out_ready_i  in  1  consumer accepts
- out_addr_o  out  32  PC of the presented instruction, bit 0 = 0
- out_rdata_o  out  32  instruction; upper half undefined if compressed
- out_err_o  out  1  fetch error on the instruction
- out_err_plus2_o  out  1  error from the second half of an unaligned instruction

## Operation
- State: rd_ptr, wr_ptr (mod DEPTH, wrap DEPTH-1 -> 0), level (0..DEPTH), addr_q[31:1].
- Head word H = entry[rd_ptr] if level>=1, else in_rdata_i/in_err_i (bypass). Next word N = entry[rd_ptr+1 mod DEPTH] if level>=2, else incoming.
- valid = (level>=1) | in_valid_i.
- err is H's error. compressed_lo = (H[1:0]!=2'b11) & ~err. compressed_hi = (H[17:16]!=2'b11) & ~err.
- Aligned (addr_q[1]=0): rdata=H, err_o=err, err_plus2=0, out_valid=valid.
- Unaligned: rdata={N[15:0],H[31:16]}.
  - If compressed_hi: out_valid=valid.
  - Else: out_valid=(level>=2) | (level==1 & in_valid_i).
  - err_o = err(H) | (err(N) & ~compressed_hi). When N comes from bypass, err(N) counts only if level>=1.
  - err_plus2 = err(N) & ~err(H).
- Handshake fire = out_valid_o & out_ready_i.
  - On fire, addr_q += compressed ? 1 : 2 (halfword units), using compressed_hi when unaligned and compressed_lo when aligned.
- pop = fire & (addr_q[1] | ~compressed_lo): the head word is fully consumed.
- push = in_valid_i & ~(level==0 & pop). A bypassed word consumed in the same cycle is not stored.
- On push: entry[wr_ptr] <= in_rdata_i/in_err_i, wr_ptr++. On pop with level>=1: rd_ptr++. level updates by push-minus-pop.
- Push with level==DEPTH is legal only together with pop. Push at full without pop: write dropped, state unchanged; an assertion flags it.
- clear_i has priority:
  - pointers and level become 0, addr_q <= in_addr_i[31:1];
  - any push or fire in the same cycle is discarded;
  - outputs in the clear cycle still reflect the pre-clear state.

## Timing
- Reset: level_o=0, busy_o=0, out_valid_o=0 (absent in_valid_i), out_addr_o=0, pointers 0. addr_q always resets.
- All outputs are combinational from state and inputs. The bypass is zero-latency: an incoming word is presented in the same cycle when level==0.
- State updates on posedge clk_i. level_o and busy_o reflect pushes and pops from the next cycle on.
- Reset asserted mid-stream clears all state immediately (asynchronously). Storage contents are don't-care unless ResetAll=1.

## Test plan
- Reset with in_valid_i=0 -> out_valid_o=0, level_o=0, busy_o=0, out_addr_o=0.
- clear_i with in_addr_i=0x80, then words 0x00000013 and 0x00100093, out_ready_i=1 -> bypass outputs at 0x80 then 0x84, with level_o=0 throughout.
- clear_i with in_addr_i=0x100, word 0x45014501 (two compressed) -> out_rdata_o[15:0]=0x4501 at 0x100 and at 0x102, a single pop, and only the second presentation pops.
- clear_i with in_addr_i=0x102, word 0x0013xxxx (upper half 0x0013), then 0xxxxx0000 -> one cycle with out_valid_o=0, then out_rdata_o=0x00000013 at 0x102, next PC 0x106.
- NUM_REQS=2, fill 3 words with out_ready_i=0 -> level_o=3, busy_o=2'b11. Then push+pop each cycle for 5 cycles -> level_o stays 3, pointers wrap, and data order is preserved.
- Unaligned uncompressed with err on N only -> out_err_o=1, out_err_plus2_o=1. With err on H -> out_err_plus2_o=0.
